siso_left_feeder: RTL

SISO_LEFT_FEEDER -- requirements
Module: siso_left_feeder

---
 rtl/siso_left_feeder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/siso_left_feeder.sv
// Feeder for a serial-in/serial-out left shifter. Buffers upstream words in a
// small FIFO and emits one word per permitted shift, as a registered
// LSHIFT strobe with OUT_DATA. With SISO_FEED_FLUSH_EN defined, a FLUSH
// request drains the shifter by issuing SISO_WIDTH shifts of the PAD word
// once the FIFO has emptied.
module siso_left_feeder #(
  parameter int unsigned          BUS_WIDTH  = 8,
  parameter int unsigned          SISO_WIDTH = 4,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [BUS_WIDTH-1:0] PAD        = '0
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            S_VALID,
  output logic                            S_READY,
  input  logic [BUS_WIDTH-1:0]            S_DATA,
  input  logic                            SHIFT_EN,
  input  logic                            FLUSH,
  output logic                            LSHIFT,
  output logic [BUS_WIDTH-1:0]            OUT_DATA,
  output logic                            BUSY,
  output logic [$clog2(FIFO_DEPTH):0]     COUNT
);

  localparam int unsigned     AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned     CW        = AW + 1;
  localparam logic [CW-1:0]   FullCount = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFeed, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [BUS_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0]   mem_d [FIFO_DEPTH];
  logic                   lshift_q, lshift_d;
  logic [BUS_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   push, pop;

`ifdef SISO_FEED_FLUSH_EN
  localparam int unsigned PW = $clog2(SISO_WIDTH + 1);
  logic                   flush_pend_q, flush_pend_d;
  logic [PW-1:0]          pad_cnt_q, pad_cnt_d;

  assign S_READY = (count_q != FullCount) && (state_q != StFlush);
`else
  logic unused_cfg;
  assign unused_cfg = FLUSH ^ (^PAD) ^ (SISO_WIDTH != 0);

  assign S_READY = (count_q != FullCount);
`endif

  assign push     = S_VALID && S_READY;
  assign pop      = SHIFT_EN && (count_q != '0) && (state_q != StFlush);
  assign LSHIFT   = lshift_q;
  assign OUT_DATA = out_data_q;
  assign COUNT    = count_q;
  assign BUSY     = (count_q != '0) || (state_q != StIdle);

  // Next-state: FIFO push/pop, output strobe, feed/flush sequencing.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    lshift_d   = 1'b0;
    out_data_d = out_data_q;
`ifdef SISO_FEED_FLUSH_EN
    flush_pend_d = flush_pend_q;
    pad_cnt_d    = pad_cnt_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q] = S_DATA;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      out_data_d = mem_q[rd_ptr_q];
      lshift_d   = 1'b1;
      rd_ptr_d   = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

`ifdef SISO_FEED_FLUSH_EN
    if (state_q == StFlush) begin
      if (SHIFT_EN) begin
        out_data_d = PAD;
        lshift_d   = 1'b1;
        pad_cnt_d  = pad_cnt_q - PW'(1);
        if (pad_cnt_q <= PW'(1)) begin
          state_d      = StIdle;
          flush_pend_d = 1'b0;
        end
      end
    end else begin
      // A flush waits behind any buffered words, including one pushed now.
      flush_pend_d = flush_pend_q | FLUSH;
      if (flush_pend_d && (count_d == '0)) begin
        state_d   = StFlush;
        pad_cnt_d = PW'(SISO_WIDTH);
      end else begin
        state_d = (count_d != '0) ? StFeed : StIdle;
      end
    end
`else
    state_d = (count_d != '0) ? StFeed : StIdle;
`endif
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lshift_q   <= 1'b0;
      out_data_q <= '0;
`ifdef SISO_FEED_FLUSH_EN
      flush_pend_q <= 1'b0;
      pad_cnt_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lshift_q   <= lshift_d;
      out_data_q <= out_data_d;
`ifdef SISO_FEED_FLUSH_EN
      flush_pend_q <= flush_pend_d;
      pad_cnt_q    <= pad_cnt_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule
